// File: rtl/tile_seq.sv
// Tile sequencer: streams weight and activation words from the input SRAM into L0
// and drives the core's weight-load / execute / drain stream over n_tiles tiles.
module tile_seq #(
   parameter int row     = 4,
   parameter int col     = 4,
   parameter int num_inp = 8,
   parameter int tw      = 8,
   parameter int aw      = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [tw-1:0] n_tiles,
   input  logic          acc_clr,
   input  logic          full_l0,
   input  logic          ready_l0,
   input  logic          o_full,
   output logic          mem_cen,
   output logic [aw-1:0] mem_addr,
   output logic          wr_l0,
   output logic          rd_l0,
   output logic [1:0]    inst_w,
   output logic          mode,
   output logic          acc,
   output logic          busy,
   output logic          done,
   output logic [tw-1:0] tile_idx
);

   localparam int cw = $clog2(row + col + num_inp + 2);
   localparam logic [cw-1:0] w_last     = cw'(row - 1);
   localparam logic [cw-1:0] x_last     = cw'(num_inp - 1);
   localparam logic [cw-1:0] d_last     = cw'(row + col);
   localparam logic [aw-1:0] tile_words = aw'(row + num_inp);

   localparam logic [1:0] inst_idle  = 2'b00;
   localparam logic [1:0] inst_wload = 2'b01;
   localparam logic [1:0] inst_exec  = 2'b10;

   typedef enum logic [2:0] {IDLE, WLOAD, GAP, EXEC, DRAIN, NEXT, DONE} state_t;

   state_t        state_q, state_d;
   logic [cw-1:0] cnt_q, cnt_d;
   logic [tw-1:0] tile_d;
   logic [tw-1:0] n_tiles_q;
   logic          acc_clr_q;
   logic          accept;

   logic [aw-1:0] ptr, total;
   logic          issue;

   assign accept = start && (state_q == IDLE);

   // Fetch side runs ahead of the read FSM; it only needs a word left and L0 headroom.
   assign issue    = !full_l0 && (ptr != total);
   assign mem_cen  = !issue;
   assign mem_addr = ptr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr   <= '0;
         total <= '0;
         wr_l0 <= 1'b0;
      end else begin
         wr_l0 <= issue;
         if (accept) begin
            ptr   <= '0;
            total <= aw'(n_tiles) * tile_words;
         end else if (issue) begin
            ptr <= ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tile_idx  <= '0;
         n_tiles_q <= '0;
         acc_clr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tile_idx <= tile_d;
         if (accept) begin
            n_tiles_q <= n_tiles;
            acc_clr_q <= acc_clr;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tile_d  = tile_idx;
      rd_l0   = 1'b0;
      inst_w  = inst_idle;
      mode    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = '0;
               tile_d  = '0;
               state_d = (n_tiles == '0) ? NEXT : WLOAD;
            end
         end
         WLOAD: begin
            if (ready_l0) begin
               rd_l0  = 1'b1;
               inst_w = inst_wload;
               if (cnt_q == w_last) begin
                  cnt_d   = '0;
                  state_d = GAP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         GAP: state_d = EXEC;
         EXEC: begin
            mode = 1'b1;
            if (ready_l0) begin
               rd_l0  = 1'b1;
               inst_w = inst_exec;
               if (cnt_q == x_last) begin
                  cnt_d   = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            // Output FIFO backpressure freezes the drain count, not the state.
            if (!o_full) begin
               if (cnt_q == d_last) begin
                  cnt_d   = '0;
                  state_d = NEXT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         NEXT: begin
            if ((n_tiles_q == '0) || (tile_idx == n_tiles_q - 1'b1)) begin
               state_d = DONE;
            end else begin
               tile_d  = tile_idx + 1'b1;
               state_d = WLOAD;
            end
         end
         DONE: begin
            done    = 1'b1;
            tile_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign acc  = !(busy && acc_clr_q && (tile_idx == '0));

endmodule

// File: tb/tb_tile_seq.sv
// Scoreboard bench for tile_seq: stimulus queues expected fetch addresses, L0 reads
// and done cycles; a negedge monitor pops and compares as the DUT produces them.
module tb_tile_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       start = 1'b0;
   logic [7:0] n_tiles = '0;
   logic       acc_clr = 1'b0;
   logic       full_l0 = 1'b0;
   logic       ready_l0 = 1'b1;
   logic       o_full = 1'b0;
   logic       mem_cen;
   logic [11:0] mem_addr;
   logic       wr_l0, rd_l0, mode, acc, busy, done;
   logic [1:0] inst_w;
   logic [7:0] tile_idx;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   int          addr_q[$];
   logic [11:0] rd_q[$];
   int          done_q[$];
   logic        prev_issue = 1'b0;

   tile_seq dut (
      .clk(clk), .reset(reset), .start(start), .n_tiles(n_tiles), .acc_clr(acc_clr),
      .full_l0(full_l0), .ready_l0(ready_l0), .o_full(o_full), .mem_cen(mem_cen),
      .mem_addr(mem_addr), .wr_l0(wr_l0), .rd_l0(rd_l0), .inst_w(inst_w), .mode(mode),
      .acc(acc), .busy(busy), .done(done), .tile_idx(tile_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   // Monitor: compares every fetch, L0 read and done pulse against the queues.
   always @(negedge clk) begin
      if (!reset) begin
         prev_issue = 1'b0;
      end else begin
         if (wr_l0 || prev_issue) check("wr_l0_latency", wr_l0, prev_issue);
         prev_issue = !mem_cen;
         if (!mem_cen) begin
            check("fetch_expected", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) check("mem_addr", mem_addr, addr_q.pop_front());
         end
         if (rd_l0) begin
            check("read_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) check("read_inst_mode_acc_tile", {inst_w, mode, acc, tile_idx}, rd_q.pop_front());
         end
         if (!rd_l0 && inst_w != 2'b00) check("inst_without_read", inst_w, 0);
         if (done) begin
            check("done_expected", done_q.size() != 0, 1);
            if (done_q.size() != 0) check("done_cycle", cyc, done_q.pop_front());
         end
      end
   end

   task automatic expect_run(input int t_cnt, input bit clr, input int s, input int extra);
      for (int i = 0; i < t_cnt * 12; i++) addr_q.push_back(i);
      for (int t = 0; t < t_cnt; t++) begin
         for (int r = 0; r < 12; r++) begin
            rd_q.push_back({(r < 4) ? 2'b01 : 2'b10, (r < 4) ? 1'b0 : 1'b1, !(clr && t == 0), 8'(t)});
         end
      end
      // Per tile: 4 weight + 1 gap + 8 exec + 9 drain + 1 next; done one cycle later.
      done_q.push_back((t_cnt == 0) ? s + 2 : s + 23 * t_cnt + 1 + extra);
   endtask

   task automatic pulse_start(input int t_cnt, input bit clr, input int extra, output int s);
      tick();
      s = cyc;
      expect_run(t_cnt, clr, s, extra);
      n_tiles = 8'(t_cnt);
      acc_clr = clr;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      acc_clr = 1'b0;
      n_tiles = 8'd3;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      @(negedge clk);
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_within_budget", done, 1);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("tile_idx_after_done", tile_idx, 0);
      check("addr_q_drained", addr_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
   endtask

   task automatic check_reset_vals();
      check("rst_mem_cen", mem_cen, 1);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_wr_l0", wr_l0, 0);
      check("rst_rd_l0", rd_l0, 0);
      check("rst_inst_w", inst_w, 0);
      check("rst_mode", mode, 0);
      check("rst_acc", acc, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tile_idx", tile_idx, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      reset = 1'b1;
      #2 reset = 1'b0;
      @(negedge clk);
      check_reset_vals();
      tick();
      reset = 1'b1;

      // Plain single tile.
      pulse_start(1, 1'b0, 0, s);
      wait_done(400);

      // L0 almost-full for 5 cycles during fetch.
      pulse_start(1, 1'b0, 0, s);
      wait_cyc(s + 4);
      full_l0 = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("no_fetch_when_full", mem_cen, 1);
         tick();
      end
      full_l0 = 1'b0;
      wait_done(400);

      // ready_l0 low 3 cycles in EXEC: three idle bubbles, done 3 cycles later.
      pulse_start(1, 1'b0, 3, s);
      wait_cyc(s + 8);
      ready_l0 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("bubble_rd_l0", rd_l0, 0);
         check("bubble_inst_w", inst_w, 0);
         tick();
      end
      ready_l0 = 1'b1;
      wait_done(400);

      // Output FIFO full 4 cycles in DRAIN, plus a start while busy.
      pulse_start(1, 1'b0, 4, s);
      wait_cyc(s + 3);
      start   = 1'b1;
      n_tiles = 8'd5;
      tick();
      start = 1'b0;
      wait_cyc(s + 16);
      o_full = 1'b1;
      repeat (4) tick();
      o_full = 1'b0;
      wait_done(400);

      // Nine tiles, tile 0 with cleared accumulators.
      pulse_start(9, 1'b1, 0, s);
      wait_done(400);

      // Zero tiles: busy one cycle then done.
      pulse_start(0, 1'b0, 0, s);
      @(negedge clk);
      check("zero_tiles_busy", busy, 1);
      wait_done(400);

      // Reset mid-EXEC aborts; restart runs from address 0, tile 0.
      pulse_start(2, 1'b0, 0, s);
      wait_cyc(s + 8);
      reset = 1'b0;
      addr_q.delete();
      rd_q.delete();
      done_q.delete();
      #1;
      check_reset_vals();
      tick();
      tick();
      reset = 1'b1;
      pulse_start(1, 1'b1, 0, s);
      wait_done(400);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
